vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Single-port frame-RAM arbiter for the VGA datapath. It shares one synchronous video RAM between three requesters: display scanout, driven by the pixel-clock enable and active-area flag from the sync counters; a host write master; and a host read master. Display scanout has absolute priority. The two host masters are served round-robin in the remaining cycles. The block sits between the hsync/vsync timing logic, the RAM macro and the host bus.

## Interface
Parameters:
- AW, 19, RAM address width (640×480 = 307200 words)
- DW, 8, pixel/data width

Ports:
- clk  in  1  system clock
- i_rst  in  1  reset, asynchronous and active-high
- i_px_clk  in  1  pixel-clock enable, one-cycle pulse
- i_addr_enb  in  1  display active-area flag, qualified by i_px_clk
- i_disp_addr  in  AW  display read address, valid with i_px_clk
- i_wr_valid  in  1  host write request
- i_wr_addr  in  AW  host write address
- i_wr_data  in  DW  host write data
- o_wr_ready  out  1  host write accepted this cycle
- i_rd_valid  in  1  host read request
- i_rd_addr  in  AW  host read address
- o_rd_ready  out  1  host read accepted this cycle
- o_rd_data  out  DW  host read data
- o_rd_valid  out  1  one-cycle pulse, o_rd_data valid
- o_px_data  out  DW  pixel data; holds its value between updates
- o_px_valid  out  1  one-cycle pulse, o_px_data updated
- o_ram_en  out  1  RAM access strobe
- o_ram_we  out  1  RAM write enable
- o_ram_addr  out  AW  RAM address
- o_ram_wdata  out  DW  RAM write data
- i_ram_rdata  in  DW  RAM read data, valid the cycle after o_ram_en && !o_ram_we

## Operation
- Request classes: DISP (i_px_clk && i_addr_enb), WR (i_wr_valid), RD (i_rd_valid).
- Each cycle exactly one class, or none, is granted.
- Priority: DISP always wins.
- If DISP is not requesting, WR and RD are arbitrated by a 1-bit round-robin pointer `last_host`:
  - Only one requesting: it is granted.
  - Both requesting: the one not equal to `last_host` is granted.
  - `last_host` updates only on a host grant.
- o_wr_ready = WR granted; o_rd_ready = RD granted. Both are combinational from the current-cycle requests.
- A display pulse with i_addr_enb=0 is not a request. Host traffic proceeds in that cycle.
- Grant stage: registers o_ram_en/we/addr/wdata from the granted request. With no grant, o_ram_en=0, o_ram_we=0, address/data hold.
- Tag pipeline: a 2-bit owner tag {NONE, DISP, RD} accompanies each read access through two register stages to route i_ram_rdata.
- Return stage (tag DISP): o_px_data <= i_ram_rdata, o_px_valid=1.
- Return stage (tag RD): o_rd_data <= i_ram_rdata, o_rd_valid=1.
- Writes carry tag NONE and produce no return.
- Host masters hold request and payload until ready. The arbiter never drops or reorders an accepted request.
- Host starvation is only possible while DISP requests every cycle. This is accepted; the team's pixel clock is ≤ clk/2.
- State reset (i_rst=1): all outputs 0; o_ram_addr=0, o_ram_wdata=0, o_px_data=0, o_rd_data=0; tags NONE; last_host=RD (so WR wins the first tie).
- Reset asserted mid-operation: in-flight tags are cleared and no valid pulse emerges for an access started before reset. Host must reissue.

## Timing
- Request accepted in cycle N → RAM strobe visible in N+1 → i_ram_rdata sampled at end of N+2 → o_px_valid/o_rd_valid high in N+3. Fixed 3-cycle read latency, no stalls.
- Write: ready in N → o_ram_we=1 in N+1.
- Back-to-back grants are allowed every cycle. Pipeline throughput is 1 access/cycle.
- Reads to the address written in the previous cycle return the new data, given RAM write-first behaviour. The arbiter adds no forwarding.
- Simultaneous DISP+WR+RD: DISP granted, both readys 0, last_host unchanged.
- Reset is asynchronous: outputs reach reset values without a clock edge. Deassertion is synchronous to clk via an external synchroniser.

## Test plan
- Reset: assert i_rst with no clock edge → all outputs 0. Release, then WR+RD both valid → o_wr_ready=1 first, o_rd_ready=1 the next cycle.
- Display latency: RAM[0x100]=0xA5; i_px_clk=1, i_addr_enb=1, i_disp_addr=0x100 at N → o_ram_en=1, addr 0x100 at N+1; o_px_valid=1, o_px_data=0xA5 at N+3; o_px_data holds afterwards.
- Priority: DISP, WR and RD asserted together for 1 cycle → only DISP granted, readys 0. Next cycle WR granted, then RD.
- Round-robin: WR and RD continuously valid for 6 cycles with no DISP → grants alternate WR,RD,WR,RD,WR,RD. Exactly 3 o_rd_valid pulses, with data matching the written values.
- Blanking: i_px_clk pulses every 4 cycles with i_addr_enb=0, plus continuous RD → RD granted every cycle, o_px_valid never 1.
- Reset mid-flight: RD accepted at N, i_rst pulsed in N+1 → no o_rd_valid at N+3. After release, reissued RD returns correct data.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter
// Shares one single-port synchronous video RAM between display scanout and
// two host masters (write and read). Display scanout always wins; the host
// masters share the remaining cycles round-robin. Every read carries an owner
// tag down a two-stage pipeline so the RAM read data can be routed to the
// pixel or host return port. Read latency is fixed at three cycles.
//
// Ports
//   clk, i_rst      system clock, asynchronous active-high reset
//   i_px_clk        pixel-clock enable pulse
//   i_addr_enb      display active-area flag (qualified by i_px_clk)
//   i_disp_addr     display read address
//   i_wr_*          host write request / address / data, o_wr_ready accept
//   i_rd_*          host read request / address, o_rd_ready accept
//   o_rd_data/valid host read return
//   o_px_data/valid pixel return (o_px_data holds between updates)
//   o_ram_*         RAM strobe, write enable, address, write data
//   i_ram_rdata     RAM read data, valid the cycle after a read strobe
module vram_arbiter #(
   parameter int AW = 19,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          i_rst,
   input  logic          i_px_clk,
   input  logic          i_addr_enb,
   input  logic [AW-1:0] i_disp_addr,
   input  logic          i_wr_valid,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [DW-1:0] i_wr_data,
   output logic          o_wr_ready,
   input  logic          i_rd_valid,
   input  logic [AW-1:0] i_rd_addr,
   output logic          o_rd_ready,
   output logic [DW-1:0] o_rd_data,
   output logic          o_rd_valid,
   output logic [DW-1:0] o_px_data,
   output logic          o_px_valid,
   output logic          o_ram_en,
   output logic          o_ram_we,
   output logic [AW-1:0] o_ram_addr,
   output logic [DW-1:0] o_ram_wdata,
   input  logic [DW-1:0] i_ram_rdata
);

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_DISP = 2'd1,
      TAG_RD   = 2'd2
   } tag_t;

   localparam logic HOST_WR = 1'b0;
   localparam logic HOST_RD = 1'b1;

   // Stage 0 is aligned with the RAM strobe, stage 1 with i_ram_rdata.
   localparam int TAG_STAGES = 2;

   logic          disp_req;
   logic          grant_disp;
   logic          grant_wr;
   logic          grant_rd;
   logic          last_host_reg;
   logic          last_host_next;
   tag_t          tag_next;
   tag_t          tag_reg [TAG_STAGES];

   logic          ram_en_reg;
   logic          ram_we_reg;
   logic [AW-1:0] ram_addr_reg;
   logic [DW-1:0] ram_wdata_reg;
   logic [DW-1:0] px_data_reg;
   logic          px_valid_reg;
   logic [DW-1:0] rd_data_reg;
   logic          rd_valid_reg;

   // ------------------------------------------------------------------
   // Arbitration (combinational, current-cycle requests)
   // ------------------------------------------------------------------
   always_comb begin
      disp_req       = i_px_clk & i_addr_enb;
      grant_disp     = disp_req;
      grant_wr       = 1'b0;
      grant_rd       = 1'b0;
      last_host_next = last_host_reg;
      tag_next       = TAG_NONE;

      if (!disp_req) begin
         // On a tie the host that was not served last wins.
         grant_wr = i_wr_valid & (!i_rd_valid | (last_host_reg == HOST_RD));
         grant_rd = i_rd_valid & (!i_wr_valid | (last_host_reg == HOST_WR));
      end

      if (grant_wr) begin
         last_host_next = HOST_WR;
      end else if (grant_rd) begin
         last_host_next = HOST_RD;
      end

      if (grant_disp) begin
         tag_next = TAG_DISP;
      end else if (grant_rd) begin
         tag_next = TAG_RD;
      end
   end

   assign o_wr_ready = grant_wr;
   assign o_rd_ready = grant_rd;

   // ------------------------------------------------------------------
   // Grant stage: drive the RAM from the granted request
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         ram_en_reg    <= 1'b0;
         ram_we_reg    <= 1'b0;
         ram_addr_reg  <= '0;
         ram_wdata_reg <= '0;
         last_host_reg <= HOST_RD;
      end else begin
         ram_en_reg    <= grant_disp | grant_wr | grant_rd;
         ram_we_reg    <= grant_wr;
         last_host_reg <= last_host_next;
         // Address and write data hold when nothing is granted.
         if (grant_disp) begin
            ram_addr_reg <= i_disp_addr;
         end else if (grant_wr) begin
            ram_addr_reg  <= i_wr_addr;
            ram_wdata_reg <= i_wr_data;
         end else if (grant_rd) begin
            ram_addr_reg <= i_rd_addr;
         end
      end
   end

   // ------------------------------------------------------------------
   // Owner tag pipeline; reset clears in-flight tags so no return pulse
   // can escape for an access issued before reset.
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < TAG_STAGES; gi++) begin : g_tag
         tag_t tag_in;
         if (gi == 0) begin : g_first
            assign tag_in = tag_next;
         end else begin : g_rest
            assign tag_in = tag_reg[gi-1];
         end

         always_ff @(posedge clk or posedge i_rst) begin
            if (i_rst) begin
               tag_reg[gi] <= TAG_NONE;
            end else begin
               tag_reg[gi] <= tag_in;
            end
         end
      end
   endgenerate

   // ------------------------------------------------------------------
   // Return stage: route RAM read data by owner tag
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         px_data_reg  <= '0;
         px_valid_reg <= 1'b0;
         rd_data_reg  <= '0;
         rd_valid_reg <= 1'b0;
      end else begin
         px_valid_reg <= (tag_reg[TAG_STAGES-1] == TAG_DISP);
         rd_valid_reg <= (tag_reg[TAG_STAGES-1] == TAG_RD);
         if (tag_reg[TAG_STAGES-1] == TAG_DISP) begin
            px_data_reg <= i_ram_rdata;
         end
         if (tag_reg[TAG_STAGES-1] == TAG_RD) begin
            rd_data_reg <= i_ram_rdata;
         end
      end
   end

   assign o_ram_en    = ram_en_reg;
   assign o_ram_we    = ram_we_reg;
   assign o_ram_addr  = ram_addr_reg;
   assign o_ram_wdata = ram_wdata_reg;
   assign o_px_data   = px_data_reg;
   assign o_px_valid  = px_valid_reg;
   assign o_rd_data   = rd_data_reg;
   assign o_rd_valid  = rd_valid_reg;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter
// Directed bench for vram_arbiter with a write-first synchronous RAM model.
// Every host read return is checked against an expected-data queue filled
// when the read is accepted.
module tb_vram_arbiter;

   localparam int AW = 19;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          i_rst;
   logic          i_px_clk;
   logic          i_addr_enb;
   logic [AW-1:0] i_disp_addr;
   logic          i_wr_valid;
   logic [AW-1:0] i_wr_addr;
   logic [DW-1:0] i_wr_data;
   logic          o_wr_ready;
   logic          i_rd_valid;
   logic [AW-1:0] i_rd_addr;
   logic          o_rd_ready;
   logic [DW-1:0] o_rd_data;
   logic          o_rd_valid;
   logic [DW-1:0] o_px_data;
   logic          o_px_valid;
   logic          o_ram_en;
   logic          o_ram_we;
   logic [AW-1:0] o_ram_addr;
   logic [DW-1:0] o_ram_wdata;
   logic [DW-1:0] i_ram_rdata;

   int tests_run = 0;
   int tests_failed = 0;
   int rd_cnt = 0;
   int px_cnt = 0;
   logic [DW-1:0] exp_rd_q[$];

   vram_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk         (clk),
      .i_rst       (i_rst),
      .i_px_clk    (i_px_clk),
      .i_addr_enb  (i_addr_enb),
      .i_disp_addr (i_disp_addr),
      .i_wr_valid  (i_wr_valid),
      .i_wr_addr   (i_wr_addr),
      .i_wr_data   (i_wr_data),
      .o_wr_ready  (o_wr_ready),
      .i_rd_valid  (i_rd_valid),
      .i_rd_addr   (i_rd_addr),
      .o_rd_ready  (o_rd_ready),
      .o_rd_data   (o_rd_data),
      .o_rd_valid  (o_rd_valid),
      .o_px_data   (o_px_data),
      .o_px_valid  (o_px_valid),
      .o_ram_en    (o_ram_en),
      .o_ram_we    (o_ram_we),
      .o_ram_addr  (o_ram_addr),
      .o_ram_wdata (o_ram_wdata),
      .i_ram_rdata (i_ram_rdata)
   );

   always #5 clk = ~clk;

   // Write-first single-port synchronous RAM
   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (o_ram_en) begin
         if (o_ram_we) begin
            mem[o_ram_addr] <= o_ram_wdata;
            i_ram_rdata     <= o_ram_wdata;
         end else begin
            i_ram_rdata <= mem[o_ram_addr];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Return monitor: every host read pulse must match the next expected word
   always @(negedge clk) begin
      if (!i_rst && o_rd_valid) begin
         rd_cnt++;
         if (exp_rd_q.size() == 0) begin
            check("rd_unexpected", 32'(o_rd_valid), 0);
         end else begin
            check("rd_data", 32'(o_rd_data), 32'(exp_rd_q.pop_front()));
         end
      end
      if (!i_rst && o_px_valid) begin
         px_cnt++;
      end
   end

   int wk;
   int rk;
   int cnt0;

   initial begin
      i_rst = 1'b0; i_px_clk = 1'b0; i_addr_enb = 1'b0; i_disp_addr = '0;
      i_wr_valid = 1'b0; i_wr_addr = '0; i_wr_data = '0;
      i_rd_valid = 1'b0; i_rd_addr = '0;
      mem[AW'(32'h100)] = 8'hA5;

      // Reset without any clock edge
      #2 i_rst = 1'b1;
      #1;
      check("rst_ram_en",    32'(o_ram_en), 0);
      check("rst_ram_we",    32'(o_ram_we), 0);
      check("rst_ram_addr",  32'(o_ram_addr), 0);
      check("rst_ram_wdata", 32'(o_ram_wdata), 0);
      check("rst_px_data",   32'(o_px_data), 0);
      check("rst_px_valid",  32'(o_px_valid), 0);
      check("rst_rd_data",   32'(o_rd_data), 0);
      check("rst_rd_valid",  32'(o_rd_valid), 0);
      repeat (2) @(posedge clk);
      #1 i_rst = 1'b0;
      step();

      // First tie after reset: WR then RD
      i_wr_valid = 1'b1; i_wr_addr = AW'(32'h10); i_wr_data = 8'h3C;
      i_rd_valid = 1'b1; i_rd_addr = AW'(32'h100);
      @(negedge clk);
      check("tie_wr_ready", 32'(o_wr_ready), 1);
      check("tie_rd_ready", 32'(o_rd_ready), 0);
      step();
      i_wr_valid = 1'b0;
      @(negedge clk);
      check("tie2_rd_ready", 32'(o_rd_ready), 1);
      check("wr_ram_we",     32'(o_ram_we), 1);
      check("wr_ram_addr",   32'(o_ram_addr), 32'h10);
      check("wr_ram_wdata",  32'(o_ram_wdata), 32'h3C);
      exp_rd_q.push_back(8'hA5);
      step();
      i_rd_valid = 1'b0;
      repeat (4) step();

      // Display latency
      i_px_clk = 1'b1; i_addr_enb = 1'b1; i_disp_addr = AW'(32'h100);
      step();
      i_px_clk = 1'b0; i_addr_enb = 1'b0;
      @(negedge clk);
      check("disp_ram_en",   32'(o_ram_en), 1);
      check("disp_ram_we",   32'(o_ram_we), 0);
      check("disp_ram_addr", 32'(o_ram_addr), 32'h100);
      step();
      @(negedge clk);
      check("disp_n2_valid", 32'(o_px_valid), 0);
      step();
      @(negedge clk);
      check("disp_n3_valid", 32'(o_px_valid), 1);
      check("disp_n3_data",  32'(o_px_data), 32'hA5);
      step();
      @(negedge clk);
      check("disp_n4_valid", 32'(o_px_valid), 0);
      check("disp_hold",     32'(o_px_data), 32'hA5);
      repeat (2) step();

      // Priority: DISP + WR + RD together; last_host is RD so WR follows
      i_px_clk = 1'b1; i_addr_enb = 1'b1; i_disp_addr = AW'(32'h100);
      i_wr_valid = 1'b1; i_wr_addr = AW'(32'h20); i_wr_data = 8'h11;
      i_rd_valid = 1'b1; i_rd_addr = AW'(32'h10);
      @(negedge clk);
      check("pri_wr_ready", 32'(o_wr_ready), 0);
      check("pri_rd_ready", 32'(o_rd_ready), 0);
      step();
      i_px_clk = 1'b0; i_addr_enb = 1'b0;
      @(negedge clk);
      check("pri2_wr_ready", 32'(o_wr_ready), 1);
      check("pri2_rd_ready", 32'(o_rd_ready), 0);
      check("pri2_ram_addr", 32'(o_ram_addr), 32'h100);
      step();
      i_wr_valid = 1'b0;
      @(negedge clk);
      check("pri3_rd_ready", 32'(o_rd_ready), 1);
      check("pri3_ram_addr", 32'(o_ram_addr), 32'h20);
      exp_rd_q.push_back(8'h3C);
      step();
      i_rd_valid = 1'b0;
      repeat (4) step();

      // Round-robin with continuous WR and RD; each read targets the word
      // written the cycle before.
      wk = 0; rk = 0;
      cnt0 = rd_cnt;
      for (int i = 0; i < 6; i++) begin
         i_wr_valid = 1'b1; i_wr_addr = AW'(32'h40 + wk); i_wr_data = DW'(32'h50 + wk);
         i_rd_valid = 1'b1; i_rd_addr = AW'(32'h40 + rk);
         @(negedge clk);
         check("rr_wr_ready", 32'(o_wr_ready), (i % 2 == 0) ? 1 : 0);
         check("rr_rd_ready", 32'(o_rd_ready), (i % 2 == 1) ? 1 : 0);
         if (o_wr_ready) wk++;
         if (o_rd_ready) begin
            exp_rd_q.push_back(DW'(32'h50 + rk));
            rk++;
         end
         step();
      end
      i_wr_valid = 1'b0; i_rd_valid = 1'b0;
      repeat (4) step();
      check("rr_rd_pulses", 32'(rd_cnt - cnt0), 3);

      // Blanking: pixel pulses with i_addr_enb=0 never block host reads
      cnt0 = px_cnt;
      for (int i = 0; i < 8; i++) begin
         i_px_clk = (i % 4 == 0); i_addr_enb = 1'b0;
         i_rd_valid = 1'b1; i_rd_addr = AW'(32'h100);
         @(negedge clk);
         check("blank_rd_ready", 32'(o_rd_ready), 1);
         if (o_rd_ready) exp_rd_q.push_back(8'hA5);
         step();
      end
      i_px_clk = 1'b0; i_rd_valid = 1'b0;
      repeat (4) step();
      check("blank_px_pulses", 32'(px_cnt - cnt0), 0);

      // Reset while a read is in flight
      i_rd_valid = 1'b1; i_rd_addr = AW'(32'h10);
      @(negedge clk);
      check("mid_rd_ready", 32'(o_rd_ready), 1);
      step();
      i_rd_valid = 1'b0;
      i_rst = 1'b1;
      #1;
      check("mid_async_ram_en", 32'(o_ram_en), 0);
      step();
      i_rst = 1'b0;
      step();
      @(negedge clk);
      check("mid_no_rd_valid", 32'(o_rd_valid), 0);
      step();
      i_rd_valid = 1'b1; i_rd_addr = AW'(32'h10);
      @(negedge clk);
      check("reissue_rd_ready", 32'(o_rd_ready), 1);
      exp_rd_q.push_back(8'h3C);
      step();
      i_rd_valid = 1'b0;
      repeat (5) step();

      check("exp_queue_drained", 32'(exp_rd_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
